// File: rtl/codec_init_sequencer.sv
// rtl/codec_init_sequencer.sv - codec power-up register sequencer over the I2C write engine
//
// Walks a fixed table of 16-bit codec register words, issuing one I2C write
// per word with NACK retry, WAIT_BUSY/WAIT_DONE timeouts and a fixed
// inter-transfer gap. Reports done or fail.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_start        start request, sampled only in IDLE/DONE/FAIL
//   i_i2c_ready    engine idle (1) / transfer in progress (0)
//   i_i2c_error    NACK flag, valid when i_i2c_ready returns high
//   o_i2c_subaddr  first byte {reg_addr[6:0], reg_data[8]}
//   o_i2c_data     second byte reg_data[7:0]
//   o_i2c_write    one-cycle write request
//   o_busy         sequence in progress
//   o_done         all entries acknowledged (held)
//   o_fail         entry exhausted retries or timed out (held)
//   o_reg_index    current / failing table index
module codec_init_sequencer #(
  parameter int NUM_REGS       = 11,
  parameter int RETRY_MAX      = 3,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_i2c_ready,
  input  logic       i_i2c_error,
  output logic [7:0] o_i2c_subaddr,
  output logic [7:0] o_i2c_data,
  output logic       o_i2c_write,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fail,
  output logic [3:0] o_reg_index
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);

  localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [CW-1:0] BUSY_LAST = CW'(3);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_index;
  logic [RW-1:0] r_retry;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          r_tmo;
  logic [15:0]   w_word;

  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0017;
      4'd2:    table_word = 16'h0217;
      4'd3:    table_word = 16'h047F;
      4'd4:    table_word = 16'h067F;
      4'd5:    table_word = 16'h0812;
      4'd6:    table_word = 16'h0A00;
      4'd7:    table_word = 16'h0C00;
      4'd8:    table_word = 16'h0E02;
      4'd9:    table_word = 16'h1000;
      4'd10:   table_word = 16'h1201;
      default: table_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: if (i_start) w_next = S_LOAD;
      S_LOAD:                 if (i_i2c_ready) w_next = S_ISSUE;
      S_ISSUE:                w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!i_i2c_ready)           w_next = S_WAIT_DONE;
        else if (r_cnt == BUSY_LAST) w_next = S_CHECK;
      end
      S_WAIT_DONE:            if (i_i2c_ready || r_cnt == TMO_LAST) w_next = S_CHECK;
      S_CHECK: begin
        // A completion timeout means the bus is wedged; retrying cannot help.
        if (r_tmo || (r_err && r_retry == RETRY_LIM)) w_next = S_FAIL;
        else if (r_err)                                w_next = S_GAP;
        else if (r_index == LAST_IDX)                  w_next = S_DONE;
        else                                           w_next = S_GAP;
      end
      S_GAP:                  if (r_cnt == GAP_LAST) w_next = S_LOAD;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_index <= '0;
      r_retry <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            r_index <= '0;
            r_retry <= '0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT_BUSY: begin
          if (!i_i2c_ready) begin
            r_cnt <= '0;
          end else if (r_cnt == BUSY_LAST) begin
            // Engine never acknowledged the request: handle like a NACK.
            r_err <= 1'b1;
            r_tmo <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (i_i2c_ready) begin
            r_err <= i_i2c_error;
            r_tmo <= 1'b0;
          end else if (r_cnt == TMO_LAST) begin
            r_err <= 1'b1;
            r_tmo <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_cnt <= '0;
          if (!r_tmo) begin
            if (r_err) begin
              if (r_retry < RETRY_LIM) r_retry <= r_retry + 1'b1;
            end else if (r_index != LAST_IDX) begin
              r_index <= r_index + 4'd1;
              r_retry <= '0;
            end
          end
        end
        S_GAP: if (r_cnt != GAP_LAST) r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign w_word        = table_word(r_index);
  assign o_busy        = r_state inside {S_LOAD, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_CHECK, S_GAP};
  assign o_i2c_write   = (r_state == S_ISSUE);
  assign o_done        = (r_state == S_DONE);
  assign o_fail        = (r_state == S_FAIL);
  assign o_reg_index   = r_index;
  // Bytes are only presented while a sequence runs so that reset/idle drive zeros.
  assign o_i2c_subaddr = o_busy ? w_word[15:8] : 8'h00;
  assign o_i2c_data    = o_busy ? w_word[7:0]  : 8'h00;

endmodule
